// File: rtl/pc_gen_unit.sv
// Next-PC generator: owns the PC, drives the fetch handshake, resolves branches,
// takes trap redirects, halts on ebreak and counts retired instructions.
// Optional: define PC_GEN_MISALIGN_EN to trap misaligned targets into HALT.
module pc_gen_unit #(
    parameter int          XLEN         = 32,
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter int          CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic             commit_valid,
    input  logic             if_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  pc,
    output logic             if_valid,
    output logic [2:0]       pc_src,
    output logic             br_taken,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic             misalign_err
);

    localparam logic [XLEN-1:0] RST_PC = RESET_VECTOR[XLEN-1:0];

    localparam logic [2:0] SRC_PLUS4  = 3'b000;
    localparam logic [2:0] SRC_JALR   = 3'b010;
    localparam logic [2:0] SRC_BRANCH = 3'b011;
    localparam logic [2:0] SRC_JAL    = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  instret_q;
    logic              if_valid_q;
    logic              halted_q;
    logic              misalign_q;

    logic [XLEN-1:0]   next_pc_d;
    logic [XLEN-1:0]   jalr_sum;
    logic              is_ebreak;
    logic              next_mis;
    logic              redir_mis;

    always_comb begin
        case (opcode)
            7'b1100111: pc_src = SRC_JALR;
            7'b1100011: pc_src = SRC_BRANCH;
            7'b1101111: pc_src = SRC_JAL;
            default:    pc_src = SRC_PLUS4;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        if (pc_src == SRC_BRANCH) begin
            case (funct3)
                3'b000:  br_taken = (rs1_val == rs2_val);
                3'b001:  br_taken = (rs1_val != rs2_val);
                3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
                3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
                3'b110:  br_taken = (rs1_val <  rs2_val);
                3'b111:  br_taken = (rs1_val >= rs2_val);
                default: br_taken = 1'b0;
            endcase
        end
    end

    assign jalr_sum = rs1_val + imm;

    always_comb begin
        case (pc_src)
            SRC_JAL:    next_pc_d = pc_q + imm;
            SRC_JALR:   next_pc_d = {jalr_sum[XLEN-1:1], 1'b0};
            SRC_BRANCH: next_pc_d = br_taken ? (pc_q + imm) : (pc_q + XLEN'(4));
            default:    next_pc_d = pc_q + XLEN'(4);
        endcase
    end

    assign is_ebreak = (opcode == 7'b1110011) && (funct3 == 3'b000) && (imm[11:0] == 12'h001);

`ifdef PC_GEN_MISALIGN_EN
    assign next_mis  = |next_pc_d[1:0];
    assign redir_mis = |redirect_pc[1:0];
`else
    assign next_mis  = 1'b0;
    assign redir_mis = 1'b0;
`endif

    // Redirect outranks both fetch acceptance and commit; a misaligned target parks in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RST_PC;
            instret_q  <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    if_valid_q <= 1'b1;
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        if (redir_mis) begin
                            state_q    <= S_HALT;
                            if_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (if_ready) begin
                        state_q    <= S_EXEC;
                        if_valid_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (redirect_valid) begin
                        if (redir_mis) begin
                            state_q    <= S_HALT;
                            halted_q   <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q       <= redirect_pc;
                            state_q    <= S_FETCH;
                            if_valid_q <= 1'b1;
                        end
                    end else if (commit_valid) begin
                        if (is_ebreak) begin
                            instret_q <= instret_q + 1'b1;
                            state_q   <= S_HALT;
                            halted_q  <= 1'b1;
                        end else if (next_mis) begin
                            state_q    <= S_HALT;
                            halted_q   <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q       <= next_pc_d;
                            instret_q  <= instret_q + 1'b1;
                            state_q    <= S_FETCH;
                            if_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign if_valid     = if_valid_q;
    assign halted       = halted_q;
    assign instret      = instret_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm, rs1_val, rs2_val;
    logic        commit_valid, if_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_valid;
    logic [2:0]  pc_src;
    logic        br_taken;
    logic        halted;
    logic [63:0] instret;
    logic        misalign_err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;
    logic [2:0]  obs_src;
    logic        obs_taken;

    pc_gen_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .commit_valid(commit_valid),
        .if_ready(if_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc(pc), .if_valid(if_valid), .pc_src(pc_src), .br_taken(br_taken),
        .halted(halted), .instret(instret), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] model_src(input logic [6:0] op);
        if (op == 7'b1100111) return 3'b010;
        if (op == 7'b1100011) return 3'b011;
        if (op == 7'b1101111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic model_taken(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        if (op != 7'b1100011) return 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa <  sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua <  ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [31:0] im,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        if (op == 7'b1101111) return cur + im;
        if (op == 7'b1100111) begin
            t = a + im;
            t[0] = 1'b0;
            return t;
        end
        if (model_taken(op, f3, a, b)) return cur + im;
        return cur + 32'd4;
    endfunction

    // ---------------- stimulus drivers ----------------
    task automatic idle_inputs();
        opcode = 7'b0010011; funct3 = 3'd0; imm = '0; rs1_val = '0; rs2_val = '0;
        commit_valid = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    // Starts just after a clock edge with the unit in FETCH; returns after the commit edge.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] im,
                             input logic [31:0] a, input logic [31:0] b, input int stall,
                             input int wait_c, input logic redir, input logic [31:0] rtgt);
        if_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        if_ready = 1'b1;
        @(posedge clk); #1;
        if_ready = 1'b0;
        repeat (wait_c) begin @(posedge clk); #1; end
        opcode = op; funct3 = f3; imm = im; rs1_val = a; rs2_val = b;
        commit_valid = 1'b1; redirect_valid = redir; redirect_pc = rtgt;
        #1;
        obs_src = pc_src;
        obs_taken = br_taken;
        @(posedge clk); #1;
        commit_valid = 1'b0; redirect_valid = 1'b0; opcode = 7'b0010011;
        $display("[%0t] instr op=%b f3=%b imm=%h redir=%b -> pc=%h instret=%0d",
                 $time, op, f3, im, redir, pc, instret);
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic with_ready);
        redirect_valid = 1'b1; redirect_pc = tgt; if_ready = with_ready;
        @(posedge clk); #1;
        redirect_valid = 1'b0; if_ready = 1'b0;
        $display("[%0t] redirect tgt=%h ready=%b -> pc=%h", $time, tgt, with_ready, pc);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_instret = '0;
        $display("[%0t] reset cycle done pc=%h", $time, pc);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
        rst_n = 1'b1;
        #2;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL idle_gap_if_valid: got %b want 0", if_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_if_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (pc !== RV) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, RV); end
            @(posedge clk); #1;
        end
        exp_instret = '0;
        $display("[%0t] reset/stall test done", $time);
    endtask

    task automatic test_jal();
        run_instr(7'b1101111, 3'd0, 32'h10, 32'd0, 32'd0, 0, 0, 1'b0, 32'd0);
        exp_instret = exp_instret + 1;
        n_cmp++; if (obs_src !== 3'b100) begin n_fail++; $display("FAIL jal_src: got %b want 100", obs_src); end
        n_cmp++; if (pc !== 32'h8000_0010) begin n_fail++; $display("FAIL jal_pc: got %h want 80000010", pc); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL jal_instret: got %0d want %0d", instret, exp_instret); end
        n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL jal_if_valid: got %b want 1", if_valid); end
    endtask

    task automatic test_branches();
        do_redirect(32'h8000_0100, 1'b0);
        run_instr(7'b1100011, 3'b100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 1, 1, 1'b0, 32'd0);
        exp_instret = exp_instret + 1;
        n_cmp++; if (obs_taken !== 1'b1) begin n_fail++; $display("FAIL blt_taken: got %b want 1", obs_taken); end
        n_cmp++; if (obs_src !== 3'b011) begin n_fail++; $display("FAIL blt_src: got %b want 011", obs_src); end
        n_cmp++; if (pc !== 32'h8000_00F8) begin n_fail++; $display("FAIL blt_pc: got %h want 800000f8", pc); end
        do_redirect(32'h8000_0100, 1'b1);
        n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_fetch_if_valid: got %b want 1", if_valid); end
        n_cmp++; if (pc !== 32'h8000_0100) begin n_fail++; $display("FAIL redir_fetch_pc: got %h want 80000100", pc); end
        run_instr(7'b1100011, 3'b110, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0, 32'd0);
        exp_instret = exp_instret + 1;
        n_cmp++; if (obs_taken !== 1'b0) begin n_fail++; $display("FAIL bltu_taken: got %b want 0", obs_taken); end
        n_cmp++; if (pc !== 32'h8000_0104) begin n_fail++; $display("FAIL bltu_pc: got %h want 80000104", pc); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL br_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_jalr();
        logic [31:0] start_pc;
        start_pc = pc;
        run_instr(7'b1100111, 3'd0, 32'd2, 32'h8000_0201, 32'd0, 0, 0, 1'b0, 32'd0);
        n_cmp++; if (obs_src !== 3'b010) begin n_fail++; $display("FAIL jalr_src: got %b want 010", obs_src); end
`ifdef PC_GEN_MISALIGN_EN
        n_cmp++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL jalr_misalign: got %b want 1", misalign_err); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL jalr_halted: got %b want 1", halted); end
        n_cmp++; if (pc !== start_pc) begin n_fail++; $display("FAIL jalr_pc_hold: got %h want %h", pc, start_pc); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL jalr_instret: got %0d want %0d", instret, exp_instret); end
        @(posedge clk); #1;
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign_pulse: got %b want 0", misalign_err); end
        do_reset();
`else
        exp_instret = exp_instret + 1;
        n_cmp++; if (pc !== 32'h8000_0202) begin n_fail++; $display("FAIL jalr_pc: got %h want 80000202 (from %h)", pc, start_pc); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign: got %b want 0", misalign_err); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL jalr_instret: got %0d want %0d", instret, exp_instret); end
`endif
    endtask

    task automatic test_redirect();
        run_instr(7'b1101111, 3'd0, 32'h40, 32'd0, 32'd0, 0, 2, 1'b1, 32'h8000_1000);
        n_cmp++; if (pc !== 32'h8000_1000) begin n_fail++; $display("FAIL redir_pc: got %h want 80001000", pc); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL redir_instret: got %0d want %0d", instret, exp_instret); end
        n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_state_fetch: got if_valid=%b want 1", if_valid); end
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [11:0] i12;
        logic [31:0] im, a, b, tgt, want_pc;
        logic [2:0]  want_src;
        logic        want_taken, redir;
        int          kind;
        exp_pc = pc;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            tgt = $urandom & 32'hFFFF_FFFC;
            if (kind == 0) begin
                do_redirect(tgt, 1'($urandom_range(0, 1)));
                exp_pc = tgt;
                n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_fetch_redir_pc[%0d]: got %h want %h", n, pc, exp_pc); end
            end else begin
                case ($urandom_range(0, 3))
                    0:       op = 7'b1101111;
                    1:       op = 7'b1100111;
                    2:       op = 7'b1100011;
                    default: begin
                        op = 7'($urandom);
                        if (op == 7'b1101111 || op == 7'b1100111 || op == 7'b1100011) op = 7'b0110011;
                    end
                endcase
                f3 = 3'($urandom);
                i12 = 12'($urandom);
                i12[1:0] = 2'b00;
                im = {{20{i12[11]}}, i12};
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if (op == 7'b1100111) a = a & 32'hFFFF_FFFC;
                redir = (kind == 1);
                want_src   = model_src(op);
                want_taken = model_taken(op, f3, a, b);
                want_pc    = redir ? tgt : model_next(exp_pc, op, f3, im, a, b);
                run_instr(op, f3, im, a, b, $urandom_range(0, 2), $urandom_range(0, 2), redir, tgt);
                if (!redir) exp_instret = exp_instret + 1;
                exp_pc = want_pc;
                n_cmp++; if (obs_src !== want_src) begin n_fail++; $display("FAIL rnd_src[%0d]: got %b want %b", n, obs_src, want_src); end
                n_cmp++; if (obs_taken !== want_taken) begin n_fail++; $display("FAIL rnd_taken[%0d]: got %b want %b", n, obs_taken, want_taken); end
                n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, exp_pc); end
                n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL rnd_instret[%0d]: got %0d want %0d", n, instret, exp_instret); end
            end
        end
    endtask

    task automatic test_ebreak_halt();
        logic [31:0] hold_pc;
        hold_pc = pc;
        run_instr(7'b1110011, 3'd0, 32'd1, 32'd0, 32'd0, 0, 1, 1'b0, 32'd0);
        exp_instret = exp_instret + 1;
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ebreak_halted: got %b want 1", halted); end
        n_cmp++; if (pc !== hold_pc) begin n_fail++; $display("FAIL ebreak_pc: got %h want %h", pc, hold_pc); end
        n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL ebreak_instret: got %0d want %0d", instret, exp_instret); end
        if_ready = 1'b1; commit_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_4000;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (if_valid !== 1'b0 || halted !== 1'b1 || pc !== hold_pc)
                begin n_fail++; $display("FAIL halt_hold[%0d]: got if_valid=%b halted=%b pc=%h want 0/1/%h", i, if_valid, halted, pc, hold_pc); end
            @(posedge clk); #1;
        end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_halted: got %b want 0", halted); end
        n_cmp++; if (pc !== RV) begin n_fail++; $display("FAIL halt_reset_pc: got %h want %h", pc, RV); end
        n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL halt_reset_instret: got %0d want 0", instret); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL restart_if_valid: got %b want 1", if_valid); end
        $display("[%0t] ebreak/halt test done", $time);
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branches();
        test_jalr();
        test_redirect();
        test_random();
        test_ebreak_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised next-PC generator for the NPC core. It replaces the pure opcode-to-select decode with an owned PC register and a fetch handshake, and adds:
- in-unit branch resolution for all six RV32I/RV64I branch conditions
- a trap/flush redirect port
- an ebreak halt state
- a retired-instruction counter

It sits between IFU and EXU and drives the fetch address.

Parameters:
XLEN, 32, datapath/PC width (32 or 64)
RESET_VECTOR, 32'h8000_0000 (zero-extended to XLEN), PC value after reset
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  opcode of the instruction in EXEC
funct3  in  3  funct3 of that instruction
imm  in  XLEN  sign-extended immediate
rs1_val  in  XLEN  rs1 operand
rs2_val  in  XLEN  rs2 operand
commit_valid  in  1  EXU retires the current instruction this cycle
if_ready  in  1  IFU accepts the fetch address
redirect_valid  in  1  trap/mret flush request
redirect_pc  in  XLEN  flush target
pc  out  XLEN  current PC
if_valid  out  1  fetch request valid
pc_src  out  3  decoded source: 000 plus4, 010 jalr, 011 branch, 100 jal
br_taken  out  1  branch condition result (combinational, valid in EXEC)
halted  out  1  core stopped on ebreak
instret  out  CNT_W  retired-instruction count
misalign_err  out  1  misaligned-target pulse (see Optional Feature)

Behaviour:
Reset values (async, immediate):
- pc=RESET_VECTOR, state=IDLE, if_valid=0, halted=0, instret=0, misalign_err=0.

State machine (IDLE, FETCH, EXEC, HALT):
- IDLE: first clock after reset release -> FETCH. Gives a one-cycle gap before the first fetch.
- FETCH: if_valid=1; pc held stable. if_ready=1 -> EXEC. if_valid must not drop before acceptance.
- EXEC: if_valid=0; waits any number of cycles for commit_valid.
- On commit_valid: pc<=next_pc, instret+=1, -> FETCH.
- On commit_valid with ebreak (opcode 1110011, funct3 000, imm[11:0]=1): instret+=1, pc unchanged, -> HALT.
- HALT: halted=1, if_valid=0. Only reset leaves HALT.

pc_src decode (combinational from opcode):
- 1100111 -> 010 (jalr)
- 1100011 -> 011 (branch)
- 1101111 -> 100 (jal)
- all others -> 000 (plus4)

next_pc (all arithmetic modulo 2^XLEN; wrap-around silent):
- 000: pc+4
- 100: pc+imm
- 010: (rs1_val+imm) & ~1
- 011: pc+imm if br_taken, else pc+4

br_taken by funct3:
- 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge
- 010/011: 0
- forced 0 when pc_src!=011

Redirect:
- Highest priority, in FETCH or EXEC: pc<=redirect_pc, -> FETCH. A same-cycle commit_valid is discarded (instret not incremented).
- In FETCH, redirect overrides if_ready acceptance.
- Ignored in IDLE and HALT.

Reset mid-operation:
- Any state returns immediately to reset values; an in-flight fetch is abandoned.

Optional Feature:
Macro PC_GEN_MISALIGN_EN.
- Defined: a computed next_pc or redirect_pc with bits[1:0]!=0 on a commit/redirect cycle (bit0 already cleared for jalr) is not loaded. Instead:
  - misalign_err pulses 1 for one cycle
  - instret is not incremented
  - pc holds the faulting instruction's PC
  - -> HALT
- Undefined: targets are loaded unchecked; misalign_err tied 0.

Test Plan:
- Reset release -> pc=0x8000_0000, if_valid=0 for one cycle then 1; if_ready held 0 for 3 cycles -> if_valid stays 1, pc unchanged.
- pc=0x8000_0000, opcode 1101111, imm=0x10, commit -> pc=0x8000_0010, pc_src=100, instret=1.
- Branches at pc=0x8000_0100, imm=-8:
  - funct3 100, rs1=0xFFFF_FFFF, rs2=1 -> taken, pc=0x8000_00F8
  - funct3 110, same operands -> not taken, pc=0x8000_0104
- jalr rs1=0x8000_0201, imm=2 -> pc=0x8000_0202 (macro off). With macro on -> misalign_err pulse, HALT, pc unchanged.
- commit_valid and redirect_valid together with redirect_pc=0x8000_1000 -> pc=0x8000_1000, instret unchanged, state FETCH.
- ebreak commit -> halted=1 next cycle, if_valid=0 for 10 cycles; rst_n low mid-HALT -> halted=0 immediately.
